// File: rtl/mem_read_unit_pkg.sv
// mem_read_unit_pkg: shared size codes, FSM states and alignment helper
package mem_read_unit_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Reserved size behaves as a word, so it needs full word alignment.
    function automatic logic misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
        return (size == SIZE_BYTE) ? 1'b0 :
               (size == SIZE_HALF) ? addr_lo[0] : (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/load_extract.sv
// load_extract: select and extend the addressed byte/half/word of a memory word
module load_extract
    import mem_read_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = rdata[{addr_lo, 3'b000} +: 8];
    assign lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Byte and half are extended to 32 bits; word and reserved pass through.
    always_comb begin
        result = (size == SIZE_BYTE) ? {{24{sign_ext & lane_b[7]}}, lane_b} :
                 (size == SIZE_HALF) ? {{16{sign_ext & lane_h[15]}}, lane_h} : rdata;
    end

endmodule

// File: rtl/mem_read_unit.sv
// mem_read_unit: multicycle load path issuing a memory read and holding the extended result
module mem_read_unit
    import mem_read_unit_pkg::*;
#(
    parameter int TIMEOUT   = 15,
    parameter int CNT_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] data_o
);

    state_t               state;
    logic [1:0]           addr_lo;
    logic [1:0]           size_q;
    logic                 sx_q;
    logic [CNT_WIDTH-1:0] cnt;
    logic [31:0]          ext;

    load_extract u_extract (
        .rdata   (mem_rdata),
        .addr_lo (addr_lo),
        .size    (size_q),
        .sign_ext(sx_q),
        .result  (ext)
    );

    // Access FSM; every output is registered so the controller sees clean levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            addr_lo  <= 2'b00;
            size_q   <= 2'b00;
            sx_q     <= 1'b0;
            cnt      <= '0;
            mem_req  <= 1'b0;
            mem_addr <= 32'h0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            data_o   <= 32'h0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr_lo  <= addr[1:0];
                        size_q   <= size;
                        sx_q     <= sign_ext;
                        mem_addr <= {addr[31:2], 2'b00};
                        busy     <= 1'b1;
                        if (misaligned(addr[1:0], size)) begin
                            error <= 1'b1;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            error   <= 1'b0;
                            mem_req <= 1'b1;
                            state   <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        data_o  <= ext;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end else if (cnt == CNT_WIDTH'(TIMEOUT - 1)) begin
                        error   <= 1'b1;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_read_unit.sv
// tb_mem_read_unit: table-driven load accesses checked through a completion scoreboard
module tb_mem_read_unit;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        reset, start, sign_ext, mem_ack;
    logic [31:0] addr, mem_rdata;
    logic [1:0]  size;
    logic        mem_req, busy, done, error;
    logic [31:0] mem_addr, data_o;

    mem_read_unit #(.TIMEOUT(TMO), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .size(size),
        .sign_ext(sign_ext), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .busy(busy), .done(done),
        .error(error), .data_o(data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sx;
        logic [31:0] rdata;
        int          delay;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          reqs;
        int          t0;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   reqcnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            reqcnt = 0;
        end else begin
            if (mem_req) reqcnt++;
            if (done) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done data_o %h error %b (cycle %0d)", data_o, error, cyc);
                end else begin
                    e = sbq.pop_front();
                    check("data_o", data_o, e.data);
                    check("error", {31'b0, error}, {31'b0, e.err});
                    check("latency", cyc - e.t0, e.lat);
                    check("req_cycles", reqcnt, e.reqs);
                end
                reqcnt = 0;
            end
        end
    end

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40 && busy; i++) begin
            @(posedge clk); #1;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_stuck_busy got busy=1 expected 0", name);
        end
    endtask

    task automatic run(input vec_t v);
        exp_t e;
        bit   mis, to;
        mis = (v.size == 2'b01 && v.addr[0]) || (v.size[1] && v.addr[1:0] != 2'b00);
        to  = v.delay >= TMO;
        @(posedge clk); #1;
        start = 1'b1; addr = v.addr; size = v.size; sign_ext = v.sx;
        e.t0   = cyc;
        e.data = v.exp_data;
        e.err  = v.exp_err;
        e.lat  = mis ? 1 : to ? TMO + 2 : 3 + v.delay;
        e.reqs = mis ? 0 : to ? TMO + 1 : 2 + v.delay;
        sbq.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", {31'b0, busy}, 32'd1);
        check("mem_req_after_start", {31'b0, mem_req}, {31'b0, !mis});
        if (!mis) begin
            check("mem_addr", mem_addr, {v.addr[31:2], 2'b00});
            check("error_cleared", {31'b0, error}, 32'd0);
            @(posedge clk); #1;
            if (!to) begin
                repeat (v.delay) begin
                    @(posedge clk); #1;
                end
                mem_ack = 1'b1; mem_rdata = v.rdata;
                @(posedge clk); #1;
                mem_ack = 1'b0; mem_rdata = $urandom();
            end
        end
        wait_idle("run");
        check("idle_data_hold", data_o, v.exp_data);
        check("idle_error_sticky", {31'b0, error}, {31'b0, v.exp_err});
    endtask

    vec_t vt[16];
    exp_t e2;

    initial begin
        vt[0]  = '{32'h100, 2'b10, 1'b0, 32'hDEADBEEF, 0,  32'hDEADBEEF, 1'b0};
        vt[1]  = '{32'h103, 2'b00, 1'b1, 32'h80FF1234, 0,  32'hFFFFFF80, 1'b0};
        vt[2]  = '{32'h103, 2'b00, 1'b0, 32'h80FF1234, 1,  32'h00000080, 1'b0};
        vt[3]  = '{32'h102, 2'b01, 1'b1, 32'h8001ABCD, 0,  32'hFFFF8001, 1'b0};
        vt[4]  = '{32'h101, 2'b01, 1'b1, 32'h8001ABCD, 0,  32'hFFFF8001, 1'b1};
        vt[5]  = '{32'h108, 2'b10, 1'b0, 32'h00000000, 99, 32'hFFFF8001, 1'b1};
        vt[6]  = '{32'h200, 2'b00, 1'b1, 32'h1234567F, 2,  32'h0000007F, 1'b0};
        vt[7]  = '{32'h201, 2'b00, 1'b0, 32'h0000AB00, 1,  32'h000000AB, 1'b0};
        vt[8]  = '{32'h100, 2'b01, 1'b0, 32'h1234F00D, 0,  32'h0000F00D, 1'b0};
        vt[9]  = '{32'h100, 2'b01, 1'b1, 32'h1234F00D, 3,  32'hFFFFF00D, 1'b0};
        vt[10] = '{32'h104, 2'b11, 1'b0, 32'hCAFEF00D, 0,  32'hCAFEF00D, 1'b0};
        vt[11] = '{32'h102, 2'b10, 1'b0, 32'h00000000, 0,  32'hCAFEF00D, 1'b1};
        vt[12] = '{32'h102, 2'b00, 1'b1, 32'h00450000, 0,  32'h00000045, 1'b0};
        vt[13] = '{32'h012, 2'b01, 1'b0, 32'h77770000, 14, 32'h00007777, 1'b0};
        vt[14] = '{32'h103, 2'b11, 1'b0, 32'h00000000, 0,  32'h00007777, 1'b1};
        vt[15] = '{32'h1FC, 2'b10, 1'b1, 32'h89ABCDEF, 5,  32'h89ABCDEF, 1'b0};

        reset = 1'b1; start = 1'b0; addr = '0; size = '0; sign_ext = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_error", {31'b0, error}, 32'd0);
        check("rst_data_o", data_o, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) run(vt[i]);

        // reset while waiting for memory aborts the access and ignores a late ack
        @(posedge clk); #1;
        start = 1'b1; addr = 32'h300; size = 2'b10;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("wait_mem_req", {31'b0, mem_req}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_mem_req", {31'b0, mem_req}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_error", {31'b0, error}, 32'd0);
        check("abort_data_o", data_o, 32'h0);
        check("abort_mem_addr", mem_addr, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        repeat (3) begin
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        check("late_ack_data_o", data_o, 32'h0);
        check("late_ack_busy", {31'b0, busy}, 32'd0);

        // a second start while busy is dropped: one done, first address kept
        @(posedge clk); #1;
        start = 1'b1; addr = 32'h400; size = 2'b10;
        e2.t0 = cyc; e2.data = 32'h0BADCAFE; e2.err = 1'b0; e2.lat = 5; e2.reqs = 4;
        sbq.push_back(e2);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; addr = 32'h500;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_start_mem_addr", mem_addr, 32'h400);
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 32'h0BADCAFE;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        wait_idle("busy_start");
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("busy_start_data_o", data_o, 32'h0BADCAFE);
        check("busy_start_still_idle", {31'b0, busy}, 32'd0);
        check("scoreboard_drained", sbq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
